// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128/256 encryptor, one round per clock, on-the-fly round keys
// S-box computed as GF(2^8) inverse (x^254) followed by the FIPS-197 affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

    always_comb begin
        x2   = gmul(a, a);
        x3   = gmul(x2, a);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
    end

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_mix_column (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col;
    assign mixed = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes_enc_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out,
    output logic                busy
);
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_t;
    fsm_t fsm_q, fsm_d;

    logic [127:0]        st_q, out_q;
    logic [KEY_BITS-1:0] kreg_q, kreg_next;
    logic [3:0]          round_q;
    logic [7:0]          rcon_q;
    logic                out_valid_q, accept, last_round, use_rcon;

    assign last_round = (fsm_q == RUN) && (round_q == 4'(NR));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        case (fsm_q)
            IDLE: in_ready = 1'b1;
            RUN:  if (last_round) fsm_d = HOLD;
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        in_ready = in_ready & reset;
        accept   = in_valid & in_ready;
        if (accept) fsm_d = RUN;
    end

    // State round: SubBytes -> ShiftRows -> MixColumns (skipped on the last round)
    logic [7:0]   sb_bytes [16];
    logic [127:0] sr_flat, mc_flat, round_out, rk_cur;

    for (genvar j = 0; j < 16; j++) begin : g_sbox
        aes_sbox u_sbox (.a(st_q[127-8*j -: 8]), .y(sb_bytes[j]));
    end
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr_flat[127-8*(r+4*c) -: 8] = sb_bytes[r + 4*((c + r) % 4)];
        end
    end
    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mix_column u_mix (.col(sr_flat[127-32*c -: 32]), .mixed(mc_flat[127-32*c -: 32]));
    end

    assign round_out = (last_round ? sr_flat : mc_flat) ^ rk_cur;

    // Key schedule: the last word of the key register feeds the word S-box
    logic [127:0] base_words, g_word;
    logic [31:0]  last_w, sub_in, sub_out, temp;

    assign base_words = kreg_q[KEY_BITS-1 -: 128];
    assign last_w     = kreg_q[31:0];
    assign sub_in     = use_rcon ? {last_w[23:0], last_w[31:24]} : last_w;

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (.a(sub_in[31-8*j -: 8]), .y(sub_out[31-8*j -: 8]));
    end

    assign temp            = sub_out ^ {(use_rcon ? rcon_q : 8'h00), 24'h0};
    assign g_word[127:96]  = base_words[127:96] ^ temp;
    assign g_word[95:64]   = base_words[95:64]  ^ g_word[127:96];
    assign g_word[63:32]   = base_words[63:32]  ^ g_word[95:64];
    assign g_word[31:0]    = base_words[31:0]   ^ g_word[63:32];

    if (KEY_BITS == 256) begin : g_k256
        // Round 1 uses the second key half unchanged; later rounds slide the 8-word window
        always_comb begin
            if (round_q == 4'd1) begin
                rk_cur    = kreg_q[127:0];
                kreg_next = kreg_q;
            end else begin
                rk_cur    = g_word;
                kreg_next = {kreg_q[127:0], g_word};
            end
        end
        assign use_rcon = ~round_q[0];
    end else begin : g_k128
        assign rk_cur    = g_word;
        assign kreg_next = g_word;
        assign use_rcon  = 1'b1;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            st_q        <= '0;
            kreg_q      <= '0;
            round_q     <= 4'd0;
            rcon_q      <= 8'h01;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                st_q    <= in ^ key[KEY_BITS-1 -: 128];
                kreg_q  <= key;
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
            end else if (fsm_q == RUN) begin
                st_q    <= round_out;
                kreg_q  <= kreg_next;
                round_q <= round_q + 4'd1;
                if (use_rcon) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
                if (last_round) out_q <= round_out;
            end
            if (last_round)
                out_valid_q <= 1'b1;
            else if (fsm_q == HOLD && out_ready)
                out_valid_q <= 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (fsm_q == RUN);
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - self-checking bench for aes_enc_iter (AES-128 and AES-256 instances)
module tb_aes_enc_iter;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              reset = 1'b0;
    logic [1:0]        in_valid_s = '0, in_ready_s, out_valid_s, out_ready_s = '0, busy_s;
    logic [1:0][127:0] in_s = '0, out_s;
    logic [1:0][255:0] key_s = '0;

    aes_enc_iter #(.KEY_BITS(128)) dut128 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .in(in_s[0]), .key(key_s[0][127:0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .out(out_s[0]), .busy(busy_s[0]));

    aes_enc_iter #(.KEY_BITS(256)) dut256 (
        .CLK(CLK), .reset(reset), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .in(in_s[1]), .key(key_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .out(out_s[1]), .busy(busy_s[1]));

    int checks = 0, passes = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input int i, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %h required %h", name, i, act, exp);
    endtask

    // Reference AES: S-box generated by the FIPS p/q walk, key expansion into a flat word array
    logic [7:0]  sb [256];
    logic [31:0] wexp [60];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int c);
        if (c == 1) return a;
        if (c == 2) return xt(a);
        return xt(a) ^ a;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic expand(input logic [255:0] k, input int nk);
        int nr;
        logic [31:0] t;
        logic [7:0] rc;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) wexp[i] = k[32*(nk-1-i) +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = wexp[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            wexp[i] = wexp[i-nk] ^ t;
        end
    endtask

    task automatic aes(input logic [127:0] pt, input logic [255:0] k, input int nk, output logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] n [16];
        int nr;
        int coef [4];
        coef = '{2, 3, 1, 1};
        nr = nk + 6;
        expand(k, nk);
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ wexp[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) n[rr+4*c] = s[rr + 4*((c+rr)%4)];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) begin
                    s[rr+4*c] = 8'h00;
                    if (r < nr)
                        for (int kk = 0; kk < 4; kk++) s[rr+4*c] ^= gm(n[kk+4*c], coef[(kk-rr+4)%4]);
                    else
                        s[rr+4*c] = n[rr+4*c];
                end
            for (int j = 0; j < 16; j++) s[j] ^= wexp[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
    endtask

    // Transaction-level model of each instance: in flight, holding, edges since accept
    logic [1:0]   m_run = '0, m_hold = '0;
    int           m_cnt [2] = '{0, 0};
    logic [127:0] m_exp [2] = '{'0, '0};
    logic [127:0] m_out [2] = '{'0, '0};
    logic         m_acc;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_run = '0; m_hold = '0;
            for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_out[i] = '0; end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_acc = in_valid_s[i] && ((!m_run[i] && !m_hold[i]) || (m_hold[i] && out_ready_s[i]));
                if (m_run[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == (i ? 14 : 10)) begin
                        m_out[i] = m_exp[i]; m_run[i] = 1'b0; m_hold[i] = 1'b1;
                    end
                end else if (m_hold[i] && out_ready_s[i]) begin
                    m_hold[i] = 1'b0;
                end
                if (m_acc) begin
                    aes(in_s[i], key_s[i], i ? 8 : 4, m_exp[i]);
                    m_run[i] = 1'b1; m_cnt[i] = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (mon_on)
            for (int i = 0; i < 2; i++) begin
                chk("mon_out_valid", i, out_valid_s[i], m_hold[i]);
                chk("mon_busy", i, busy_s[i], m_run[i]);
                chk("mon_in_ready", i, in_ready_s[i],
                    reset && ((!m_run[i] && !m_hold[i]) || (m_hold[i] && out_ready_s[i])));
                chk("mon_out", i, out_s[i], m_out[i]);
            end
    end

    localparam logic [255:0] K_C1 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K_B  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic submit(input int i, input logic [127:0] pt, input logic [255:0] k);
        int n;
        n = 0;
        in_s[i] = pt; key_s[i] = k; in_valid_s[i] = 1'b1;
        @(negedge CLK);
        while (!in_ready_s[i] && n < 60) begin @(negedge CLK); n++; end
        chk("accept_within_bound", i, in_ready_s[i], 1'b1);
        @(posedge CLK); #1;
        in_valid_s[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, output int lat);
        lat = 0;
        while (!out_valid_s[i] && lat < 40) begin @(posedge CLK); #1; lat++; end
    endtask

    initial begin
        int lat;
        logic [127:0] ct;
        build_sbox();
        chk("model_sbox_00", 0, sb[8'h00], 8'h63);
        chk("model_sbox_53", 0, sb[8'h53], 8'hed);
        expand(K_C3, 8);
        chk("model_rk2_256", 1, {wexp[8], wexp[9], wexp[10], wexp[11]},
            128'ha573c29fa176c498a97fce93a572c09c);
        aes(P_C, K_C1, 4, ct); chk("model_c1", 0, ct, C_C1);
        aes(P_B, K_B, 4, ct);  chk("model_b", 0, ct, C_B);
        aes(P_C, K_C3, 8, ct); chk("model_c3", 1, ct, C_C3);

        mon_on = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_out", i, out_s[i], 128'h0);
            chk("reset_in_ready", i, in_ready_s[i], 1'b0);
        end
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("idle_in_ready", 0, in_ready_s[0], 1'b1);

        // FIPS C.1 with latency
        out_ready_s[0] = 1'b1;
        submit(0, P_C, K_C1);
        wait_out(0, lat);
        chk("latency_128", 0, lat, 10);
        chk("out_c1", 0, out_s[0], C_C1);
        @(posedge CLK); #1;

        // Backpressure, then same-edge pop + accept of the Appendix-B vector
        out_ready_s[0] = 1'b0;
        submit(0, P_C, K_C1);
        wait_out(0, lat);
        repeat (20) @(posedge CLK);
        #1;
        chk("hold_out", 0, out_s[0], C_C1);
        chk("hold_valid", 0, out_valid_s[0], 1'b1);
        chk("hold_in_ready", 0, in_ready_s[0], 1'b0);
        out_ready_s[0] = 1'b1;
        submit(0, P_B, K_B);
        chk("pop_accept_valid", 0, out_valid_s[0], 1'b0);
        chk("pop_accept_busy", 0, busy_s[0], 1'b1);
        wait_out(0, lat);
        chk("latency_b", 0, lat, 10);
        chk("out_b", 0, out_s[0], C_B);
        @(posedge CLK); #1;

        // Key change mid-run must not disturb the captured key
        submit(0, P_C, K_C1);
        repeat (2) @(posedge CLK);
        #1;
        key_s[0] = '1;
        wait_out(0, lat);
        chk("key_change_out", 0, out_s[0], C_C1);
        @(posedge CLK); #1;

        // Reset abort at round 5
        submit(0, P_C, K_C1);
        repeat (4) @(posedge CLK);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_out", 0, out_s[0], 128'h0);
        chk("abort_valid", 0, out_valid_s[0], 1'b0);
        chk("abort_busy", 0, busy_s[0], 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        chk("after_abort_valid", 0, out_valid_s[0], 1'b0);
        chk("after_abort_out", 0, out_s[0], 128'h0);
        submit(0, P_C, K_C1);
        wait_out(0, lat);
        chk("fresh_out", 0, out_s[0], C_C1);

        // Back-to-back blocks with different keys
        submit(0, P_B, K_B);
        wait_out(0, lat);
        chk("b2b_out", 0, out_s[0], C_B);
        @(posedge CLK); #1;

        // AES-256
        out_ready_s[1] = 1'b1;
        submit(1, P_C, K_C3);
        wait_out(1, lat);
        chk("latency_256", 1, lat, 14);
        chk("out_c3", 1, out_s[1], C_C3);
        repeat (3) @(posedge CLK);
        #1;

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end
endmodule
